// File: rtl/pdi_scan_filter.sv
// Scanner for N_CH parallel 74HC165 chains with shared timing and a debounce filter.
// A scan word is published only after FILT consecutive identical scans.
module pdi_scan_filter #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned BITS     = 16,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned LOAD_CYC = 4,
  parameter int unsigned GAP_CYC  = 1000,
  parameter int unsigned FILT     = 3,
  parameter int unsigned AUTO     = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [N_CH-1:0]      pdi_dat,
  output logic [N_CH-1:0]      pdi_clk,
  output logic [N_CH-1:0]      pdi_lt,
  output logic [N_CH*BITS-1:0] DATA,
  output logic                 DATA_VALID,
  output logic                 CHANGED,
  output logic                 BUSY
);

  localparam int unsigned W       = N_CH * BITS;
  localparam int unsigned CYC_MAX = (LOAD_CYC > CLK_DIV)
                                    ? ((LOAD_CYC > GAP_CYC) ? LOAD_CYC : GAP_CYC)
                                    : ((CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC);
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned BIT_W   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned CNT_W   = $clog2(FILT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_HI, S_LO, S_CHECK, S_GAP
  } state_t;

  state_t               state, state_nxt;
  logic [CYC_W-1:0]     cyc;
  logic [CYC_W-1:0]     phase_len;
  logic                 phase_end;
  logic [BIT_W-1:0]     bit_idx;
  logic                 sample;
  logic                 busy_nxt;
  logic [N_CH-1:0]      sync1, sync2;
  logic [W-1:0]         raw, prev;
  logic [CNT_W-1:0]     cnt, cnt_inc, cnt_nxt;
  logic                 accept;
  logic                 first;

  // Length of the current timed phase
  always_comb begin
    phase_len = CYC_W'(CLK_DIV);
    case (state)
      S_LOAD:  phase_len = CYC_W'(LOAD_CYC);
      S_GAP:   phase_len = CYC_W'(GAP_CYC);
      default: phase_len = CYC_W'(CLK_DIV);
    endcase
    phase_end = (cyc == phase_len - CYC_W'(1));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; sample strobes on the last cycle of SETTLE and of each LO
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    case (state)
      S_IDLE:   if (AUTO != 0 || START) state_nxt = S_LOAD;
      S_LOAD:   if (phase_end) state_nxt = S_SETTLE;
      S_SETTLE: if (phase_end) begin
                  sample    = 1'b1;
                  state_nxt = (BITS > 1) ? S_HI : S_CHECK;
                end
      S_HI:     if (phase_end) state_nxt = S_LO;
      S_LO:     if (phase_end) begin
                  sample    = 1'b1;
                  state_nxt = (bit_idx == BIT_W'(BITS - 1)) ? S_CHECK : S_HI;
                end
      S_CHECK:  state_nxt = (AUTO == 0) ? S_IDLE : ((GAP_CYC == 0) ? S_LOAD : S_GAP);
      S_GAP:    if (phase_end) state_nxt = S_LOAD;
      default:  state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_SETTLE) || (state_nxt == S_HI) ||
               (state_nxt == S_LO) || (state_nxt == S_CHECK);
  end

  // Phase timer restarts on every state change
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                     cyc <= '0;
    else if (state_nxt != state || state == S_IDLE) cyc <= '0;
    else                                           cyc <= cyc + CYC_W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                bit_idx <= '0;
    else if (state == S_LOAD) bit_idx <= '0;
    else if (sample)          bit_idx <= bit_idx + BIT_W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pdi_dat;
      sync2 <= sync1;
    end
  end

  // Shifting in from the LSB leaves the first bit out in each chain's MSB
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      raw <= '0;
    end else if (sample) begin
      for (int c = 0; c < N_CH; c++)
        raw[c*BITS +: BITS] <= (raw[c*BITS +: BITS] << 1) | BITS'(sync2[c]);
    end
  end

  always_comb begin
    cnt_inc = (cnt == CNT_W'(FILT)) ? cnt : cnt + CNT_W'(1);
    cnt_nxt = (raw == prev && cnt != '0) ? cnt_inc : CNT_W'(1);
    accept  = (state == S_CHECK) && (cnt_nxt == CNT_W'(FILT));
  end

  // Filter state and published word
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt        <= '0;
      prev       <= '0;
      first      <= 1'b1;
      DATA       <= '0;
      DATA_VALID <= 1'b0;
      CHANGED    <= 1'b0;
    end else begin
      DATA_VALID <= accept;
      CHANGED    <= accept && (raw != DATA || first);
      if (state == S_CHECK) begin
        cnt  <= cnt_nxt;
        prev <= raw;
      end
      if (accept) begin
        DATA  <= raw;
        first <= 1'b0;
      end
    end
  end

  // Chain-facing strobes follow the state they belong to
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pdi_clk <= '0;
      pdi_lt  <= '1;
      BUSY    <= 1'b0;
    end else begin
      pdi_clk <= {N_CH{state_nxt == S_HI}};
      pdi_lt  <= {N_CH{state_nxt != S_LOAD}};
      BUSY    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_pdi_scan_filter.sv
// Bench for pdi_scan_filter: three configurations driven by 74HC165 chain models,
// expected responses queued per DUT and checked by a monitor on DATA_VALID.
`timescale 1ns/1ps
module tb_pdi_scan_filter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          scan;
    logic [31:0] data;
    logic        changed;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  bit   mon_en [3] = '{1'b1, 1'b1, 1'b1};

  // DUT A: defaults, free running
  logic        rst_a, start_a;
  logic [1:0]  dat_a, clk_a, lt_a;
  logic [31:0] data_a;
  logic        dv_a, ch_a, busy_a;
  logic [15:0] val_a [2];
  logic [15:0] sr_a  [2];

  pdi_scan_filter dut_a (
    .CLK(CLK), .RESET(rst_a), .START(start_a), .pdi_dat(dat_a), .pdi_clk(clk_a),
    .pdi_lt(lt_a), .DATA(data_a), .DATA_VALID(dv_a), .CHANGED(ch_a), .BUSY(busy_a)
  );

  // DUT B: on-demand scans, no debounce
  logic        rst_b, start_b;
  logic [1:0]  dat_b, clk_b, lt_b;
  logic [31:0] data_b;
  logic        dv_b, ch_b, busy_b;
  logic [15:0] val_b [2];
  logic [15:0] sr_b  [2];

  pdi_scan_filter #(.AUTO(0), .FILT(1)) dut_b (
    .CLK(CLK), .RESET(rst_b), .START(start_b), .pdi_dat(dat_b), .pdi_clk(clk_b),
    .pdi_lt(lt_b), .DATA(data_b), .DATA_VALID(dv_b), .CHANGED(ch_b), .BUSY(busy_b)
  );

  // DUT C: three 8-bit chains
  logic        rst_c, start_c;
  logic [2:0]  dat_c, clk_c, lt_c;
  logic [23:0] data_c;
  logic        dv_c, ch_c, busy_c;
  logic [7:0]  val_c [3];
  logic [7:0]  sr_c  [3];

  pdi_scan_filter #(.N_CH(3), .BITS(8), .FILT(1), .GAP_CYC(20)) dut_c (
    .CLK(CLK), .RESET(rst_c), .START(start_c), .pdi_dat(dat_c), .pdi_clk(clk_c),
    .pdi_lt(lt_c), .DATA(data_c), .DATA_VALID(dv_c), .CHANGED(ch_c), .BUSY(busy_c)
  );

  // 74HC165 models: parallel load on SH/LD falling, shift toward QH on clock rise
  always @(posedge clk_a[0] or negedge lt_a[0])
    for (int c = 0; c < 2; c++) sr_a[c] <= (!lt_a[0]) ? val_a[c] : {sr_a[c][14:0], 1'b0};
  always @(posedge clk_b[0] or negedge lt_b[0])
    for (int c = 0; c < 2; c++) sr_b[c] <= (!lt_b[0]) ? val_b[c] : {sr_b[c][14:0], 1'b0};
  always @(posedge clk_c[0] or negedge lt_c[0])
    for (int c = 0; c < 3; c++) sr_c[c] <= (!lt_c[0]) ? val_c[c] : {sr_c[c][6:0], 1'b0};

  always_comb begin
    for (int c = 0; c < 2; c++) dat_a[c] = sr_a[c][15];
    for (int c = 0; c < 2; c++) dat_b[c] = sr_b[c][15];
    for (int c = 0; c < 3; c++) dat_c[c] = sr_c[c][7];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic busy_of(input int w);
    case (w) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction
  function automatic logic dv_of(input int w);
    case (w) 0: return dv_a; 1: return dv_b; default: return dv_c; endcase
  endfunction
  function automatic logic ch_of(input int w);
    case (w) 0: return ch_a; 1: return ch_b; default: return ch_c; endcase
  endfunction
  function automatic logic rst_of(input int w);
    case (w) 0: return rst_a; 1: return rst_b; default: return rst_c; endcase
  endfunction
  function automatic logic [31:0] data_of(input int w);
    case (w) 0: return data_a; 1: return data_b; default: return 32'(data_c); endcase
  endfunction
  function automatic int qsize(input int w);
    case (w) 0: return q_a.size(); 1: return q_b.size(); default: return q_c.size(); endcase
  endfunction

  task automatic push_exp(input int w, input int s, input logic [31:0] d, input logic ch);
    exp_t e;
    e.scan = s; e.data = d; e.changed = ch;
    case (w)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int w, output exp_t e);
    case (w)
      0:       e = q_a.pop_front();
      1:       e = q_b.pop_front();
      default: e = q_c.pop_front();
    endcase
  endtask

  // Counts completed scans since reset and checks every DATA_VALID against the queue
  task automatic monitor(input int w);
    int   scan;
    logic bq;
    exp_t e;
    scan = 0;
    bq   = 1'b0;
    forever begin
      @(negedge CLK);
      if (rst_of(w)) begin
        scan = 0;
        bq   = 1'b0;
      end else begin
        if (bq && !busy_of(w)) scan++;
        bq = busy_of(w);
        if (dv_of(w) && mon_en[w]) begin
          if (qsize(w) == 0) begin
            total++;
            bad++;
            $display("FAIL dut%0d_unexpected_valid: pulse after scan %0d, none expected", w, scan);
          end else begin
            pop_exp(w, e);
            chk($sformatf("dut%0d_scan_index", w), 64'(scan), 64'(e.scan));
            chk($sformatf("dut%0d_data_s%0d", w, e.scan), 64'(data_of(w)), 64'(e.data));
            chk($sformatf("dut%0d_changed_s%0d", w, e.scan), 64'(ch_of(w)), 64'(e.changed));
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic wait_scan_end(input int w, input string what);
    int n;
    n = 0;
    while (!busy_of(w) && n < 3000) begin @(negedge CLK); n++; end
    while (busy_of(w) && n < 3000) begin @(negedge CLK); n++; end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s: no scan completed within 3000 cycles, got busy=%0b", what, busy_of(w));
    end
  endtask

  task automatic seq_a();
    int   n, rises;
    logic clk_q;
    push_exp(0, 3, 32'h0F0F_A5C3, 1'b1);
    push_exp(0, 4, 32'h0F0F_A5C3, 1'b0);
    repeat (4) wait_scan_end(0, "a_scan_timeout");
    val_a[0] = 16'hA5C2;
    wait_scan_end(0, "a_scan_timeout");
    val_a[0] = 16'hA5C3;
    push_exp(0, 8, 32'h0F0F_A5C3, 1'b0);
    repeat (3) wait_scan_end(0, "a_scan_timeout");
    // abort scan 9 during its 7th HI phase
    rises = 0;
    n     = 0;
    clk_q = clk_a[0];
    while (rises < 7 && n < 2000) begin
      @(negedge CLK);
      n++;
      if (clk_a[0] && !clk_q) rises++;
      clk_q = clk_a[0];
    end
    chk("a_reached_hi7", 64'(rises), 64'd7);
    @(posedge CLK);
    #1 rst_a = 1'b1;
    #1;
    chk("a_abort_pdi_clk", 64'(clk_a), 64'd0);
    chk("a_abort_pdi_lt", 64'(lt_a), 64'h3);
    chk("a_abort_data", 64'(data_a), 64'd0);
    chk("a_abort_valid", 64'(dv_a), 64'd0);
    chk("a_abort_changed", 64'(ch_a), 64'd0);
    chk("a_abort_busy", 64'(busy_a), 64'd0);
    @(posedge CLK);
    #1 rst_a = 1'b0;
    push_exp(0, 3, 32'h0F0F_A5C3, 1'b1);
    push_exp(0, 4, 32'h0F0F_A5C3, 1'b0);
    repeat (4) wait_scan_end(0, "a_scan_timeout");
    repeat (3) @(negedge CLK);
    mon_en[0] = 1'b0;
  endtask

  // Measures one full scan and the following gap of DUT A
  task automatic wave_a();
    int   n, lt_low, busy_hi, rises, bad_hi, bad_rr, gap_busy, skew, period, run;
    int   t_lt_rise, t_first, t_last;
    logic lt_q, clk_q, busy_q, fell;
    n = 0;
    while (lt_a[0] && n < 100) begin @(negedge CLK); n++; end
    lt_low = 1; busy_hi = int'(busy_a); rises = 0; bad_hi = 0; bad_rr = 0;
    gap_busy = 0; skew = 0; period = -1; run = 0;
    t_lt_rise = -1; t_first = -1; t_last = -1;
    lt_q = lt_a[0]; clk_q = clk_a[0]; busy_q = busy_a; fell = 1'b0;
    for (int t = 1; t < 3000; t++) begin
      @(negedge CLK);
      if ((lt_a != 2'b00 && lt_a != 2'b11) || (clk_a != 2'b00 && clk_a != 2'b11)) skew++;
      if (!lt_a[0] && lt_q) begin
        period = t;
        break;
      end
      if (!lt_a[0]) lt_low++;
      if (lt_a[0] && !lt_q) t_lt_rise = t;
      if (busy_a) busy_hi++;
      if (busy_q && !busy_a) fell = 1'b1;
      if (fell && busy_a) gap_busy++;
      if (clk_a[0] && !clk_q) begin
        rises++;
        if (t_first < 0) t_first = t;
        else if (t - t_last != 8) bad_rr++;
        t_last = t;
      end
      if (clk_a[0]) run++;
      if (!clk_a[0] && clk_q) begin
        if (run != 4) bad_hi++;
        run = 0;
      end
      lt_q = lt_a[0]; clk_q = clk_a[0]; busy_q = busy_a;
    end
    chk("wave_lt_low_cycles", 64'(lt_low), 64'd4);
    chk("wave_settle_cycles", 64'(t_first - t_lt_rise), 64'd4);
    chk("wave_clk_rises", 64'(rises), 64'd15);
    chk("wave_hi_phase_bad", 64'(bad_hi), 64'd0);
    chk("wave_rise_spacing_bad", 64'(bad_rr), 64'd0);
    chk("wave_busy_cycles", 64'(busy_hi), 64'd129);
    chk("wave_busy_in_gap", 64'(gap_busy), 64'd0);
    chk("wave_load_period", 64'(period), 64'd1129);
    chk("wave_bit_skew", 64'(skew), 64'd0);
  endtask

  task automatic seq_b();
    int hi, len, n;
    hi = 0;
    repeat (50) begin @(negedge CLK); hi += int'(busy_b); end
    chk("b_idle_without_start", 64'(hi), 64'd0);
    push_exp(1, 1, 32'hBEEF_1234, 1'b1);
    @(negedge CLK) start_b = 1'b1;
    @(negedge CLK) start_b = 1'b0;
    len = 0;
    n   = 0;
    while (!busy_b && n < 100) begin @(negedge CLK); n++; end
    while (busy_b && n < 1000) begin
      len++;
      if (len == 20) start_b = 1'b1;
      if (len == 21) start_b = 1'b0;
      @(negedge CLK);
      n++;
    end
    chk("b_busy_len", 64'(len), 64'd129);
    hi = 0;
    repeat (300) begin @(negedge CLK); hi += int'(busy_b); end
    chk("b_idle_after_scan", 64'(hi), 64'd0);
    val_b[0] = 16'h0001;
    val_b[1] = 16'h8000;
    push_exp(1, 2, 32'h8000_0001, 1'b1);
    @(negedge CLK) start_b = 1'b1;
    @(negedge CLK) start_b = 1'b0;
    wait_scan_end(1, "b_scan_timeout");
    repeat (10) @(negedge CLK);
    push_exp(1, 3, 32'h8000_0001, 1'b0);
    @(negedge CLK) start_b = 1'b1;
    @(negedge CLK) start_b = 1'b0;
    wait_scan_end(1, "b_scan_timeout");
    repeat (5) @(negedge CLK);
  endtask

  task automatic seq_c();
    push_exp(2, 1, 32'h003C_0180, 1'b1);
    push_exp(2, 2, 32'h003C_0180, 1'b0);
    push_exp(2, 3, 32'h003C_0180, 1'b0);
    repeat (3) wait_scan_end(2, "c_scan_timeout");
    repeat (3) @(negedge CLK);
    mon_en[2] = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    val_a[0] = 16'hA5C3; val_a[1] = 16'h0F0F;
    val_b[0] = 16'h1234; val_b[1] = 16'hBEEF;
    val_c[0] = 8'h80; val_c[1] = 8'h01; val_c[2] = 8'h3C;
    repeat (3) @(negedge CLK);
    chk("rst_pdi_clk", 64'(clk_a), 64'd0);
    chk("rst_pdi_lt", 64'(lt_a), 64'h3);
    chk("rst_data", 64'(data_a), 64'd0);
    chk("rst_valid", 64'(dv_a), 64'd0);
    chk("rst_changed", 64'(ch_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_c_pdi_lt", 64'(lt_c), 64'h7);
    chk("rst_b_busy", 64'(busy_b), 64'd0);
    @(posedge CLK);
    #1 rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    fork
      seq_a();
      wave_a();
      seq_b();
      seq_c();
    join
    repeat (5) @(negedge CLK);
    chk("a_expect_left", 64'(q_a.size()), 64'd0);
    chk("b_expect_left", 64'(q_b.size()), 64'd0);
    chk("c_expect_left", 64'(q_c.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
